nn_weight_sequencer: RTL and testbench

// Sequences signed weights from the weight BRAM into nn_adder's weight port (weights_valid/ready/idx).
// - Snoops the adder's ciphertext handshake and latches input-node index idx_N.
// - Issues OUT_NODES pipelined BRAM reads, then streams weights 0..OUT_NODES-1 under backpressure.
// - Counts completed ciphertext elements and flags layer completion.

---
 rtl/nn_weight_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_nn_weight_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_weight_sequencer.sv
// Streams signed weights for one input node to nn_adder per snooped ciphertext element,
// using credit-gated pipelined BRAM reads into a small skid FIFO.
module nn_weight_sequencer #(
    parameter int K_VAL       = 501,
    parameter int DEPTH       = 100,
    parameter int OUT_NODES   = 10,
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int AW = $clog2(DEPTH * OUT_NODES),
    localparam int CW = $clog2(DEPTH * K_VAL + 1)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic              ct_valid_in,
    input  logic              ct_ready_in,
    input  logic [9:0]        idx_N_in,
    output logic              rom_en_out,
    output logic [AW-1:0]     rom_addr_out,
    input  logic signed [2:0] rom_data_in,
    output logic              weights_valid,
    output logic signed [2:0] weights_out,
    output logic [5:0]        weights_idx,
    input  logic              weights_ready,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out
);
    localparam int IW   = 6;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_CT, ST_ISSUE, ST_DRAIN} state_t;

    state_t            r_state;
    logic [IW-1:0]     r_j;
    logic [AW-1:0]     r_base;
    logic              r_bad;
    logic [CW-1:0]     r_ctCount;
    logic              r_done;
    logic              r_err;

    logic              r_tagValid [ROM_LATENCY];
    logic              r_tagZero  [ROM_LATENCY];
    logic [IW-1:0]     r_tagJ     [ROM_LATENCY];

    logic signed [2:0] r_fifoData [FIFO_DEPTH];
    logic [IW-1:0]     r_fifoIdx  [FIFO_DEPTH];
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [NW-1:0]     r_count;

    logic [7:0]        w_inflight;
    logic              w_credit;
    logic              w_issue;
    logic              w_ctFire;
    logic              w_idxBad;
    logic [AW-1:0]     w_base;
    logic              w_push;
    logic              w_full;
    logic              w_doPush;
    logic              w_overflow;
    logic              w_pop;
    logic signed [2:0] w_pushData;

    // Every read in the tag pipe still owns a FIFO slot it will land in.
    always_comb begin
        w_inflight = '0;
        for (int s = 0; s < ROM_LATENCY; s++) begin
            w_inflight = w_inflight + {7'd0, r_tagValid[s]};
        end
    end

    assign w_credit   = (w_inflight + 8'(r_count)) < 8'(FIFO_DEPTH);
    assign w_issue    = (r_state == ST_ISSUE) && w_credit;
    assign w_ctFire   = ct_valid_in && ct_ready_in;
    assign w_idxBad   = 32'(idx_N_in) >= 32'(DEPTH);
    assign w_base     = AW'(32'(idx_N_in) * 32'(OUT_NODES));

    assign w_push     = r_tagValid[ROM_LATENCY-1];
    assign w_full     = (r_count == NW'(FIFO_DEPTH));
    assign w_doPush   = w_push && !w_full;
    assign w_overflow = w_push && w_full;
    assign w_pop      = weights_valid && weights_ready;
    assign w_pushData = r_tagZero[ROM_LATENCY-1] ? 3'sd0 : rom_data_in;

    assign rom_en_out    = w_issue && !r_bad;
    assign rom_addr_out  = rom_en_out ? AW'(r_base + AW'(r_j)) : '0;
    assign weights_valid = (r_count != '0);
    assign weights_out   = weights_valid ? r_fifoData[r_rdPtr] : 3'sd0;
    assign weights_idx   = weights_valid ? r_fifoIdx[r_rdPtr] : '0;
    assign busy_out      = (r_state != ST_IDLE);
    assign done_out      = r_done;
    assign err_out       = r_err;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int s = 0; s < ROM_LATENCY; s++) begin
                r_tagValid[s] <= 1'b0;
                r_tagZero[s]  <= 1'b0;
                r_tagJ[s]     <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            r_tagValid[0] <= w_issue;
            r_tagZero[0]  <= r_bad;
            r_tagJ[0]     <= r_j;
            for (int s = 1; s < ROM_LATENCY; s++) begin
                r_tagValid[s] <= r_tagValid[s-1];
                r_tagZero[s]  <= r_tagZero[s-1];
                r_tagJ[s]     <= r_tagJ[s-1];
            end
            if (w_doPush) begin
                r_fifoData[r_wrPtr] <= w_pushData;
                r_fifoIdx[r_wrPtr]  <= r_tagJ[ROM_LATENCY-1];
                r_wrPtr <= (r_wrPtr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= ST_IDLE;
            r_j       <= '0;
            r_base    <= '0;
            r_bad     <= 1'b0;
            r_ctCount <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_overflow) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        r_ctCount <= '0;
                        r_state   <= ST_WAIT_CT;
                    end
                end
                ST_WAIT_CT: begin
                    if (w_ctFire) begin
                        r_base  <= w_base;
                        r_bad   <= w_idxBad;
                        r_j     <= '0;
                        r_state <= ST_ISSUE;
                        if (w_idxBad) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_ctFire) begin
                        r_err <= 1'b1;
                    end
                    if (w_issue) begin
                        r_j <= r_j + 1'b1;
                        if (r_j == IW'(OUT_NODES - 1)) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_ctFire) begin
                        r_err <= 1'b1;
                    end
                    // The row ends only once the adder has taken the last output node.
                    if (w_pop && (weights_idx == IW'(OUT_NODES - 1))) begin
                        if (r_ctCount + CW'(1) == CW'(DEPTH * K_VAL)) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ctCount <= r_ctCount + CW'(1);
                            r_state   <= ST_WAIT_CT;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_weight_sequencer.sv
// Scoreboard bench for nn_weight_sequencer: a BRAM model, a queue of expected beats
// filled at each ct handshake, and a monitor that pops and compares accepted beats.
module tb_nn_weight_sequencer;
    localparam int P_K     = 2;
    localparam int P_DEPTH = 4;
    localparam int P_OUT   = 10;
    localparam int P_LAT   = 2;
    localparam int P_FD    = 4;
    localparam int AW      = $clog2(P_DEPTH * P_OUT);
    localparam int ROWS_PER_LAYER = P_DEPTH * P_K;

    typedef struct {
        logic signed [2:0] data;
        logic [5:0]        idx;
        bit                good;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              ctValid = 1'b0;
    logic              ctReady = 1'b0;
    logic [9:0]        idxN = '0;
    logic              romEn;
    logic [AW-1:0]     romAddr;
    logic signed [2:0] romData = '0;
    logic              wValid;
    logic signed [2:0] wOut;
    logic [5:0]        wIdx;
    logic              wReady = 1'b1;
    logic              busy;
    logic              done;
    logic              err;

    logic signed [2:0] romMem [2**AW];
    logic signed [2:0] romPipe = '0;

    beat_t expQ[$];
    int    nAssert = 0;
    int    nFail = 0;
    int    curBase = 0;
    int    nextJ = 0;
    bit    curBad = 1'b1;
    int    enCount = 0;
    int    popGood = 0;
    int    rowsDone = 0;
    bit    doneDue = 1'b0;
    bit    prevStall = 1'b0;
    logic signed [2:0] prevData = '0;
    logic [5:0]  prevIdx = '0;
    int    readyMode = 0;

    nn_weight_sequencer #(
        .K_VAL(P_K), .DEPTH(P_DEPTH), .OUT_NODES(P_OUT),
        .ROM_LATENCY(P_LAT), .FIFO_DEPTH(P_FD)
    ) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .ct_valid_in(ctValid), .ct_ready_in(ctReady), .idx_N_in(idxN),
        .rom_en_out(romEn), .rom_addr_out(romAddr), .rom_data_in(romData),
        .weights_valid(wValid), .weights_out(wOut), .weights_idx(wIdx),
        .weights_ready(wReady), .busy_out(busy), .done_out(done), .err_out(err)
    );

    always #5 clk = ~clk;

    // Two-cycle BRAM: data appears ROM_LATENCY cycles after the enable cycle.
    always @(posedge clk) begin
        romPipe <= romMem[romAddr];
        romData <= romPipe;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nAssert++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Consumer backpressure: 0 always ready, 1 pattern 1-0-0-1, 2 never ready, 3 random.
    initial begin
        logic [3:0] pat;
        int phase;
        pat = 4'b1001;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: wReady = 1'b1;
                1: begin
                    wReady = pat[3 - phase];
                    phase = (phase + 1) % 4;
                end
                2: wReady = 1'b0;
                default: wReady = 1'($urandom % 2);
            endcase
        end
    end

    // Monitor: ROM address checks, occupancy bound, beat scoreboard, hold-stable and done timing.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("done_pulse", int'(done), int'(doneDue));
            doneDue = 1'b0;
            if (romEn) begin
                if (curBad) begin
                    checkOutput("rom_en_suppressed", 1, 0);
                end else begin
                    checkOutput("rom_addr", int'(romAddr), curBase + nextJ);
                    nextJ++;
                    enCount++;
                    checkOutput("credit_bound", int'((enCount - popGood) <= P_FD), 1);
                end
            end
            if (prevStall) begin
                checkOutput("hold_valid", int'(wValid), 1);
                checkOutput("hold_data", int'(wOut), int'(prevData));
                checkOutput("hold_idx", int'(wIdx), int'(prevIdx));
            end
            if (wValid && wReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat_idx", int'(wIdx), -1);
                end else begin
                    beat_t e;
                    e = expQ.pop_front();
                    checkOutput("beat_idx", int'(wIdx), int'(e.idx));
                    checkOutput("beat_data", int'(wOut), int'(e.data));
                    if (e.good) popGood++;
                    if (e.idx == 6'(P_OUT - 1)) begin
                        rowsDone++;
                        if (rowsDone == ROWS_PER_LAYER) begin
                            doneDue = 1'b1;
                            rowsDone = 0;
                        end
                    end
                end
            end
            prevStall = wValid && !wReady;
            prevData  = wOut;
            prevIdx   = wIdx;
        end
    end

    task automatic resetModel();
        expQ.delete();
        curBad = 1'b1;
        nextJ = 0;
        enCount = 0;
        popGood = 0;
        rowsDone = 0;
        doneDue = 1'b0;
        prevStall = 1'b0;
    endtask

    task automatic doReset(input int cycles);
        rst = 1'b1;
        resetModel();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rom_en", int'(romEn), 0);
        checkOutput("rst_rom_addr", int'(romAddr), 0);
        checkOutput("rst_valid", int'(wValid), 0);
        checkOutput("rst_wout", int'(wOut), 0);
        checkOutput("rst_widx", int'(wIdx), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_err", int'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        rowsDone = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // A ct handshake; when accepted the ten expected beats go into the scoreboard.
    task automatic applyStimulus(input int idx, input bit accepted);
        if (accepted) begin
            curBad  = (idx >= P_DEPTH);
            curBase = idx * P_OUT;
            nextJ   = 0;
            for (int j = 0; j < P_OUT; j++) begin
                beat_t b;
                b.data = curBad ? 3'sd0 : romMem[curBase + j];
                b.idx  = 6'(j);
                b.good = !curBad;
                expQ.push_back(b);
            end
        end
        idxN = 10'(idx);
        ctValid = 1'b1;
        ctReady = 1'b1;
        @(posedge clk);
        #1;
        ctValid = 1'b0;
        ctReady = 1'b0;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("drain_timeout_left", expQ.size(), 0);
            expQ.delete();
        end
        @(posedge clk);
        #1;
        curBad = 1'b1;
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 2**AW; i++) romMem[i] = 3'($urandom);

        // Reset state, then a ct handshake in IDLE must do nothing.
        doReset(3);
        applyStimulus(1, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("idle_ct_err", int'(err), 0);
        checkOutput("idle_ct_busy", int'(busy), 0);

        $display("[TB] basic row idx 3");
        pulseStart();
        checkOutput("busy_after_start", int'(busy), 1);
        readyMode = 0;
        applyStimulus(3, 1'b1);
        lat = 0;
        while (!wValid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("first_beat_latency", lat, 2 + P_LAT);
        waitDrain(40);

        $display("[TB] backpressure rows");
        for (int r = 0; r < ROWS_PER_LAYER - 1; r++) begin
            readyMode = (r < 3) ? 1 : 3;
            applyStimulus($urandom_range(0, P_DEPTH - 1), 1'b1);
            waitDrain(200);
        end
        readyMode = 0;
        repeat (3) @(negedge clk);
        checkOutput("layer_idle", int'(busy), 0);
        checkOutput("layer_err", int'(err), 0);

        $display("[TB] bad index");
        doReset(2);
        pulseStart();
        applyStimulus(100, 1'b1);
        waitDrain(40);
        checkOutput("bad_idx_err", int'(err), 1);

        $display("[TB] extra handshake during issue");
        doReset(2);
        pulseStart();
        applyStimulus(2, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(1, 1'b0);
        @(negedge clk);
        checkOutput("extra_ct_err", int'(err), 1);
        waitDrain(40);

        $display("[TB] reset with beats pending");
        doReset(2);
        pulseStart();
        readyMode = 2;
        applyStimulus(1, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        doReset(2);
        readyMode = 0;
        repeat (5) @(negedge clk);
        checkOutput("post_rst_valid", int'(wValid), 0);
        pulseStart();
        applyStimulus(0, 1'b1);
        waitDrain(40);
        checkOutput("post_rst_err", int'(err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end
endmodule
